mountain_car_step_seq: RTL

- Episode/step sequencer for the MountainCar environment; the initiator side of the ena/valid request-response protocol that the velocity and position compute units answer.
- Holds the authoritative (pos, vel) state and accepts step and episode-reset commands from the agent.
- For each step, issues a velocity request, then a position request, applies the left-wall velocity fix, then reports the observation, reward, done and truncated.
- All data is IEEE-754 single precision; no float IP is instantiated inside this block.

---
 rtl/mountain_car_pkg.sv | 22 ++
 rtl/mountain_car_term_check.sv | 27 ++
 rtl/mountain_car_step_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mountain_car_pkg.sv
// rtl/mountain_car_pkg.sv - MountainCar float32 constants and sequencer state encoding
package mountain_car_pkg;

  localparam logic [31:0] MIN_P        = 32'hbf99999a;
  localparam logic [31:0] MAX_P        = 32'h3f19999a;
  localparam logic [31:0] GOAL_P       = 32'h3f000000;
  localparam logic [31:0] REWARD_STEP  = 32'hbf800000;
  localparam logic [31:0] FLT_ZERO     = 32'h00000000;
  localparam logic [31:0] FLT_NEG_ZERO = 32'h80000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEL_REQ,
    ST_VEL_WAIT,
    ST_POS_REQ,
    ST_POS_WAIT,
    ST_FIX,
    ST_OUT,
    ST_OUT_RST
  } state_e;

endpackage

// File: rtl/mountain_car_term_check.sv
// rtl/mountain_car_term_check.sv - combinational goal/truncation evaluation
module mountain_car_term_check
  import mountain_car_pkg::*;
#(
  parameter int POS_WL    = 32,
  parameter int VEL_WL    = 32,
  parameter int STEP_WL   = 8,
  parameter int MAX_STEPS = 200
) (
  input  logic [POS_WL-1:0]  pos_i,
  input  logic [VEL_WL-1:0]  vel_i,
  input  logic [STEP_WL-1:0] count_i,
  output logic               done_o,
  output logic               trunc_o
);

  logic pos_at_goal;
  logic vel_non_neg;

  // Positive floats order like unsigned integers, so a magnitude compare suffices.
  assign pos_at_goal = !pos_i[POS_WL-1] && (pos_i[POS_WL-2:0] >= GOAL_P[POS_WL-2:0]);
  assign vel_non_neg = !vel_i[VEL_WL-1] || (vel_i == FLT_NEG_ZERO[VEL_WL-1:0]);

  assign done_o  = pos_at_goal && vel_non_neg;
  assign trunc_o = (count_i >= STEP_WL'(MAX_STEPS)) && !done_o;

endmodule

// File: rtl/mountain_car_step_seq.sv
// rtl/mountain_car_step_seq.sv - MountainCar episode/step sequencer driving velocity and position units
module mountain_car_step_seq
  import mountain_car_pkg::*;
#(
  parameter int VEL_WL    = 32,
  parameter int POS_WL    = 32,
  parameter int ACT_WL    = 2,
  parameter int STEP_WL   = 8,
  parameter int MAX_STEPS = 200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step_valid,
  input  logic [ACT_WL-1:0] i_action,
  input  logic              i_env_rst_valid,
  input  logic [POS_WL-1:0] i_init_pos,
  output logic              o_ready,
  output logic              o_vel_ena,
  output logic [ACT_WL-1:0] o_vel_action,
  output logic [POS_WL-1:0] o_vel_pos,
  output logic [VEL_WL-1:0] o_vel_vel,
  input  logic              i_vel_valid,
  input  logic [VEL_WL-1:0] i_vel,
  output logic              o_pos_ena,
  output logic [POS_WL-1:0] o_pos_pos,
  output logic [VEL_WL-1:0] o_pos_vel,
  input  logic              i_pos_valid,
  input  logic [POS_WL-1:0] i_pos,
  output logic              o_obs_valid,
  output logic [POS_WL-1:0] o_pos,
  output logic [VEL_WL-1:0] o_vel,
  output logic [31:0]       o_reward,
  output logic              o_done,
  output logic              o_trunc
);

  state_e               state_q;
  logic [POS_WL-1:0]    pos_q, pnew_q, opos_q;
  logic [VEL_WL-1:0]    vel_q, vnew_q, ovel_q;
  logic [ACT_WL-1:0]    act_q;
  logic [STEP_WL-1:0]   cnt_q;
  logic                 vel_ena_q, pos_ena_q, obs_q, done_q, trunc_q;
  logic [31:0]          reward_q;
  logic [VEL_WL-1:0]    vfix_d;
  logic                 term_done, term_trunc;

  // Landing on the left wall while still moving left kills the velocity.
  assign vfix_d = ((pnew_q == MIN_P[POS_WL-1:0]) && vnew_q[VEL_WL-1]) ? '0 : vnew_q;

  mountain_car_term_check #(
    .POS_WL    (POS_WL),
    .VEL_WL    (VEL_WL),
    .STEP_WL   (STEP_WL),
    .MAX_STEPS (MAX_STEPS)
  ) u_term (
    .pos_i   (pos_q),
    .vel_i   (vel_q),
    .count_i (cnt_q),
    .done_o  (term_done),
    .trunc_o (term_trunc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      vel_q     <= '0;
      pnew_q    <= '0;
      vnew_q    <= '0;
      act_q     <= '0;
      cnt_q     <= '0;
      vel_ena_q <= 1'b0;
      pos_ena_q <= 1'b0;
      obs_q     <= 1'b0;
      opos_q    <= '0;
      ovel_q    <= '0;
      reward_q  <= FLT_ZERO;
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      vel_ena_q <= 1'b0;
      pos_ena_q <= 1'b0;
      obs_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_env_rst_valid) begin
            pos_q   <= i_init_pos;
            vel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
            state_q <= ST_OUT_RST;
          end else if (i_step_valid) begin
            act_q     <= i_action;
            vel_ena_q <= 1'b1;
            state_q   <= ST_VEL_REQ;
          end
        end
        ST_VEL_REQ:  state_q <= ST_VEL_WAIT;
        ST_VEL_WAIT: begin
          if (i_vel_valid) begin
            vnew_q    <= i_vel;
            pos_ena_q <= 1'b1;
            state_q   <= ST_POS_REQ;
          end
        end
        ST_POS_REQ:  state_q <= ST_POS_WAIT;
        ST_POS_WAIT: begin
          if (i_pos_valid) begin
            pnew_q  <= i_pos;
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          pos_q   <= pnew_q;
          vel_q   <= vfix_d;
          vnew_q  <= vfix_d;
          cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          obs_q    <= 1'b1;
          opos_q   <= pos_q;
          ovel_q   <= vel_q;
          reward_q <= REWARD_STEP;
          done_q   <= term_done;
          trunc_q  <= term_trunc;
          state_q  <= ST_IDLE;
        end
        ST_OUT_RST: begin
          obs_q    <= 1'b1;
          opos_q   <= pos_q;
          ovel_q   <= '0;
          reward_q <= FLT_ZERO;
          done_q   <= 1'b0;
          trunc_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_vel_ena    = vel_ena_q;
  assign o_vel_action = act_q;
  assign o_vel_pos    = pos_q;
  assign o_vel_vel    = vel_q;
  assign o_pos_ena    = pos_ena_q;
  assign o_pos_pos    = pos_q;
  assign o_pos_vel    = vnew_q;
  assign o_obs_valid  = obs_q;
  assign o_pos        = opos_q;
  assign o_vel        = ovel_q;
  assign o_reward     = reward_q;
  assign o_done       = done_q;
  assign o_trunc      = trunc_q;

endmodule
